uart_rx_fifo: RTL and testbench

//   Receive-side byte buffer directly downstream of the UART receiver. Captures each

---
 rtl/uart_rx_fifo.sv | 132 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer between the UART receiver and the CPU.
// Each byte the receiver flags as valid is pushed into a circular buffer. The CPU
// pops bytes with a one-cycle read latency. Level, full/empty and sticky-overflow
// status are available for polling.
module uart_rx_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [31:0]       wr_data,
   input  logic              rd_en,
   input  logic              clr,
   output logic [31:0]       rd_data,
   output logic              rd_valid,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count,
   output logic              overflow
);

   localparam logic [ADDR_W:0]   CNT_ONE  = 1;
   localparam logic [ADDR_W:0]   CNT_FULL = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
   localparam logic [31:0]       NO_DATA  = 32'hFFFF_FFFF;

   logic [7:0]        mem_q [DEPTH];
   logic              mem_we;

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              overflow_q, overflow_d;
   logic [31:0]       rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;

   logic              do_push, do_pop;
   logic              empty_w, full_w;

   // Only the low byte of the receiver word is stored.
   logic              unused_wr_hi;
   assign unused_wr_hi = ^wr_data[31:8];

   // Status is taken from the registered level, never from the pointers.
   assign empty_w = (count_q == '0);
   assign full_w  = (count_q == CNT_FULL);

   // Next-state logic: clr wins over push/pop; a full buffer still accepts a push
   // when a pop frees a slot in the same cycle.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      do_push    = 1'b0;
      do_pop     = 1'b0;
      mem_we     = 1'b0;

      if (clr) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end else begin
         do_pop  = rd_en && !empty_w;
         do_push = wr_en && (!full_w || rd_en);

         if (wr_en && full_w && !rd_en) begin
            overflow_d = 1'b1;
         end

         if (do_push) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end

         if (do_pop) begin
            rd_data_d  = {24'b0, mem_q[rd_ptr_q]};
            rd_valid_d = 1'b1;
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
         end else if (rd_en) begin
            rd_data_d = NO_DATA;
         end

         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // Control and output registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // Byte storage write port.
   always_ff @(posedge clk) begin
      // NOTE: storage has no reset; count and pointers alone decide which entries are live.
      if (mem_we) begin
         mem_q[wr_ptr_q] <= wr_data[7:0];
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign empty    = empty_w;
   assign full     = full_w;
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo with hand-computed expectations.
module tb_uart_rx_fifo;

   logic        clk;
   logic        rst_n;
   logic        wr_en;
   logic [31:0] wr_data;
   logic        rd_en;
   logic        clr;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        empty;
   logic        full;
   logic [4:0]  count;
   logic        overflow;

   int n_checks = 0;
   int n_errors = 0;

   uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .rd_en    (rd_en),
      .clr      (clr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .empty    (empty),
      .full     (full),
      .count    (count),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // One clock with the given inputs; returns 1 time unit after the edge.
   task automatic cycle(input logic w, input logic [31:0] d, input logic r, input logic c);
      wr_en   = w;
      wr_data = d;
      rd_en   = r;
      clr     = c;
      @(posedge clk);
      #1;
      wr_en   = 1'b0;
      wr_data = 32'h0;
      rd_en   = 1'b0;
      clr     = 1'b0;
   endtask

   task automatic push(input logic [7:0] b);
      cycle(1'b1, {24'hDEAD_BE, b}, 1'b0, 1'b0);
   endtask

   task automatic pop();
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
   endtask

   initial begin
      rst_n   = 1'b0;
      wr_en   = 1'b0;
      wr_data = 32'h0;
      rd_en   = 1'b0;
      clr     = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Reset state
      check("rst_count",    32'(count),    32'd0);
      check("rst_empty",    32'(empty),    32'd1);
      check("rst_full",     32'(full),     32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_rd_data",  rd_data,       32'h0);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1. Three bytes in, three bytes out
      push(8'h41);
      push(8'h42);
      push(8'h43);
      check("t1_count", 32'(count), 32'd3);
      check("t1_empty", 32'(empty), 32'd0);
      pop();
      check("t1_pop0_data",  rd_data,       32'h41);
      check("t1_pop0_valid", 32'(rd_valid), 32'd1);
      pop();
      check("t1_pop1_data",  rd_data,       32'h42);
      check("t1_pop1_valid", 32'(rd_valid), 32'd1);
      pop();
      check("t1_pop2_data",  rd_data,       32'h43);
      check("t1_pop2_valid", 32'(rd_valid), 32'd1);
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
      check("t1_valid_drop", 32'(rd_valid), 32'd0);
      check("t1_data_hold",  rd_data,       32'h43);
      check("t1_empty_end",  32'(empty),    32'd1);

      // 2. Fill, overflow, drain
      for (int i = 0; i < 16; i++) push(8'(i));
      check("t2_full",  32'(full),  32'd1);
      check("t2_count", 32'(count), 32'd16);
      check("t2_ovf0",  32'(overflow), 32'd0);
      push(8'hAA);
      check("t2_ovf1",        32'(overflow), 32'd1);
      check("t2_count_after", 32'(count),    32'd16);
      for (int i = 0; i < 16; i++) begin
         pop();
         check($sformatf("t2_drain%0d", i), rd_data, 32'(i));
      end
      check("t2_empty",   32'(empty),    32'd1);
      check("t2_ovf_sticky", 32'(overflow), 32'd1);
      pop();
      check("t2_no_aa_data",  rd_data,       32'hFFFF_FFFF);
      check("t2_no_aa_valid", 32'(rd_valid), 32'd0);
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      check("t2_clr_ovf",  32'(overflow), 32'd0);
      check("t2_clr_data", rd_data,       32'hFFFF_FFFF);

      // 3. Pop on empty with simultaneous push
      cycle(1'b1, 32'h0000_0055, 1'b1, 1'b0);
      check("t3_sentinel", rd_data,       32'hFFFF_FFFF);
      check("t3_valid",    32'(rd_valid), 32'd0);
      check("t3_count",    32'(count),    32'd1);
      pop();
      check("t3_pop_data",  rd_data,       32'h55);
      check("t3_pop_valid", 32'(rd_valid), 32'd1);
      check("t3_count_end", 32'(count),    32'd0);

      // 4. Push and pop together on a full buffer
      for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
      check("t4_full_pre", 32'(full), 32'd1);
      cycle(1'b1, 32'h0000_0099, 1'b1, 1'b0);
      check("t4_oldest", rd_data,       32'h10);
      check("t4_valid",  32'(rd_valid), 32'd1);
      check("t4_count",  32'(count),    32'd16);
      check("t4_ovf",    32'(overflow), 32'd0);
      for (int i = 1; i < 16; i++) begin
         pop();
         check($sformatf("t4_drain%0d", i), rd_data, 32'(8'h10 + i));
      end
      pop();
      check("t4_last_99", rd_data,    32'h99);
      check("t4_empty",   32'(empty), 32'd1);

      // 5. Wrap-around with interleaved push/pop pairs
      for (int i = 0; i < 40; i++) begin
         push(8'(8'h60 + i));
         check($sformatf("t5_cnt%0d", i), 32'(count), 32'd1);
         pop();
         check($sformatf("t5_data%0d", i), rd_data, 32'(8'h60 + i));
      end
      check("t5_empty", 32'(empty), 32'd1);

      // 6. Asynchronous reset mid-stream, then clr
      for (int i = 0; i < 16; i++) push(8'(8'hA0 + i));
      push(8'hEE);
      for (int i = 0; i < 11; i++) pop();
      check("t6_pre_count", 32'(count),    32'd5);
      check("t6_pre_ovf",   32'(overflow), 32'd1);
      check("t6_pre_data",  rd_data,       32'hAA);
      rst_n = 1'b0;
      #1;
      check("t6_rst_empty", 32'(empty),    32'd1);
      check("t6_rst_count", 32'(count),    32'd0);
      check("t6_rst_ovf",   32'(overflow), 32'd0);
      check("t6_rst_data",  rd_data,       32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      push(8'hB1);
      push(8'hB2);
      push(8'hB3);
      pop();
      check("t6_first_after_rst", rd_data, 32'hB1);
      push(8'hB4);
      check("t6_count3", 32'(count), 32'd3);
      cycle(1'b1, 32'h0000_00CC, 1'b1, 1'b1);
      check("t6_clr_count", 32'(count),    32'd0);
      check("t6_clr_empty", 32'(empty),    32'd1);
      check("t6_clr_data",  rd_data,       32'hB1);
      check("t6_clr_valid", 32'(rd_valid), 32'd0);
      pop();
      check("t6_after_clr_data", rd_data, 32'hFFFF_FFFF);
      push(8'hC5);
      pop();
      check("t6_after_clr_push", rd_data, 32'hC5);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
